// File: rtl/reg_read_port_pkg.sv
// Shared definitions for the register file and its read port.
// DEF_N      : default register data width
// DEF_ADDR_W : default register index width (32 registers)
// ZERO_REG   : index of the hard-wired zero register
package reg_read_port_pkg;
    localparam int DEF_N      = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/reg_read_port_stage.sv
// pipe_stage: a single pipeline register, which holds a valid bit and a payload.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears valid and payload)
//   i_load     : capture i_data and set valid (takes priority over i_clear)
//   i_clear    : drop valid; the payload is left as it was
//   i_data     : payload to capture
//   o_valid    : stage holds an entry
//   o_data     : stage payload
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/reg_read_port.sv
// reg_read_port: a two-stage read port in front of a combinational register file.
// S1 holds the requested index and drives the storage read mux. S2 holds the
// registered response. A write to the S1 index in the same cycle is forwarded.
// Ports:
//   clk, reset               : clock and synchronous active-high reset
//   req_valid/ready/addr     : read request handshake
//   wr_en/wr_addr/wr_data    : register file write port, snooped for bypass
//   rf_rd_addr/rf_rd_data    : storage read mux index and data
//   rsp_valid/ready/data/addr: response handshake
//   served_count             : saturating count of accepted responses
module reg_read_port
    import reg_read_port_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [N-1:0]      rf_rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [15:0]       served_count
);
    logic                     w_s1_valid;
    logic [ADDR_W-1:0]        w_s1_addr;
    logic                     w_s2_valid;
    logic [ADDR_W+N-1:0]      w_s2_payload;
    logic                     w_s1_adv;
    logic                     w_req_acc;
    logic                     w_rsp_acc;
    logic [N-1:0]             w_rd_data;
    logic [15:0]              r_served_count;

    assign w_s1_adv  = w_s1_valid && (!w_s2_valid || rsp_ready);
    // Reset gates ready so nothing is accepted in a reset cycle.
    assign req_ready = !reset && (!w_s1_valid || w_s1_adv);
    assign w_req_acc = req_valid && req_ready;
    assign w_rsp_acc = w_s2_valid && rsp_ready;

    // Zero register wins over both storage and bypass; a same-cycle write
    // to the S1 index wins over the stale storage value.
    always_comb begin
        w_rd_data = rf_rd_data;
        if (w_s1_addr == ADDR_W'(ZERO_REG))
            w_rd_data = '0;
        else if (wr_en && (wr_addr == w_s1_addr))
            w_rd_data = wr_data;
    end

    pipe_stage #(.W(ADDR_W)) u_s1 (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_req_acc),
        .i_clear (w_s1_adv),
        .i_data  (req_addr),
        .o_valid (w_s1_valid),
        .o_data  (w_s1_addr)
    );

    pipe_stage #(.W(ADDR_W + N)) u_s2 (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_s1_adv),
        .i_clear (w_rsp_acc),
        .i_data  ({w_s1_addr, w_rd_data}),
        .o_valid (w_s2_valid),
        .o_data  (w_s2_payload)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_served_count <= '0;
        else if (w_rsp_acc && (r_served_count != 16'hFFFF))
            r_served_count <= r_served_count + 16'd1;
    end

    // A stalled S1 keeps driving its index, so storage is re-read every cycle.
    assign rf_rd_addr   = w_s1_addr;
    assign rsp_valid    = w_s2_valid;
    assign rsp_addr     = w_s2_payload[ADDR_W+N-1:N];
    assign rsp_data     = w_s2_payload[N-1:0];
    assign served_count = r_served_count;
endmodule

// File: tb/tb_reg_read_port.sv
module tb_reg_read_port;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [4:0]  req_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_addr;
    logic [15:0] served_count;

    logic [31:0] mem [32];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Register file model: written by the writer port, read combinationally.
    always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
    assign rf_rd_data = mem[rf_rd_addr];

    reg_read_port dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .served_count(served_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];
    int   hs;
    int   cyc;

    initial begin
        vecs[0] = '{5'd5,  1'b0, 5'd0,  32'h0,         32'h1234_5678};
        vecs[1] = '{5'd7,  1'b1, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{5'd0,  1'b0, 5'd0,  32'h0,         32'h0};
        vecs[3] = '{5'd0,  1'b1, 5'd0,  32'h5555_5555, 32'h0};
        vecs[4] = '{5'd9,  1'b1, 5'd10, 32'hCAFE_F00D, 32'hA000_0009};
        vecs[5] = '{5'd31, 1'b0, 5'd0,  32'h0,         32'hA000_001F};

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Preload storage through the write port while the DUT is in reset.
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            if (i < 32) begin wr_addr = 5'(i); wr_data = 32'hA000_0000 | 32'(i); end
            else if (i == 32) begin wr_addr = 5'd5; wr_data = 32'h1234_5678; end
            else if (i == 33) begin wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; end
            else begin wr_addr = 5'd7; wr_data = 32'h7777_7777; end
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("rst_ready_low", req_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_served", served_count, 0);
        chk("rst_req_ready", req_ready, 1);

        // Single requests, unstalled, with optional S1-cycle write.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_addr = vecs[i].addr; rsp_ready = 1'b1;
            @(negedge clk);
            chk("vec_latency", rsp_valid, 0);
            req_valid = 1'b0; req_addr = 5'h1F;
            wr_en = vecs[i].wen; wr_addr = vecs[i].waddr; wr_data = vecs[i].wdata;
            @(negedge clk);
            chk("vec_valid", rsp_valid, 1);
            chk("vec_data", rsp_data, vecs[i].exp);
            chk("vec_addr", rsp_addr, 32'(vecs[i].addr));
            wr_en = 1'b0;
            @(negedge clk);
            chk("vec_drained", rsp_valid, 0);
        end
        chk("served_after_vecs", served_count, 6);

        // Back-to-back 1,2,3 with a stalled consumer.
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 5'd1;
        @(negedge clk);
        chk("bp_ready_s2_empty", req_ready, 1);
        req_addr = 5'd2;
        @(negedge clk);
        chk("bp_ready_full", req_ready, 0);
        chk("bp_valid", rsp_valid, 1);
        chk("bp_addr1", rsp_addr, 1);
        req_addr = 5'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_ready", req_ready, 0);
            chk("bp_hold_addr", rsp_addr, 1);
            chk("bp_hold_data", rsp_data, 32'hA000_0001);
            wr_en = (k == 0);
            wr_addr = 5'd1; wr_data = 32'hBAD0_0001;
        end
        wr_en = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_addr2", rsp_addr, 2);
        chk("bp_data2", rsp_data, 32'hA000_0002);
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_addr3", rsp_addr, 3);
        chk("bp_data3", rsp_data, 32'hA000_0003);
        @(negedge clk);
        chk("bp_drained", rsp_valid, 0);
        chk("served_after_bp", served_count, 9);

        // Reset with both stages full.
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 5'd4;
        @(negedge clk);
        req_addr = 5'd6;
        @(negedge clk);
        chk("mid_full", rsp_valid, 1);
        reset = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        @(negedge clk);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_served", served_count, 0);
        chk("mid_rsp_data", rsp_data, 0);
        chk("mid_rsp_addr", rsp_addr, 0);
        reset = 1'b0; req_valid = 1'b0;
        #1;
        chk("mid_ready_after", req_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_no_stale", rsp_valid, 0);
        end

        // Saturation of served_count with a full-throughput stream.
        req_valid = 1'b1; req_addr = 5'd3; rsp_ready = 1'b1;
        hs = 0; cyc = 0;
        while (hs < 65535 && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            if (hs < 65535 && rsp_valid && rsp_ready) hs++;
        end
        if (hs < 65535) begin
            n_chk++; n_fail++;
            $display("FAIL sat_timeout: got %0d handshakes expected 65535", hs);
        end
        // The handshake counted at the last negedge lands on the next edge.
        @(negedge clk);
        req_valid = 1'b0;
        chk("sat_reach", served_count, 32'hFFFF);
        chk("sat_more_pending", rsp_valid, 1);
        @(negedge clk);
        chk("sat_hold", served_count, 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_read_port.md
REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 SHALL have parameter N, default 32, data width of each register.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  read request present.
REQ-006 SHALL have port req_ready  output  1  port can accept a request this cycle.
REQ-007 SHALL have port req_addr  input  ADDR_W  register index to read.
REQ-008 SHALL have port wr_en  input  1  writer-side enable of the register file, snooped for bypass.
REQ-009 SHALL have port wr_addr  input  ADDR_W  writer-side destination index.
REQ-010 SHALL have port wr_data  input  N  writer-side data.
REQ-011 SHALL have port rf_rd_addr  output  ADDR_W  index driven to the storage read mux.
REQ-012 SHALL have port rf_rd_data  input  N  combinational storage read data for rf_rd_addr.
REQ-013 SHALL have port rsp_valid  output  1  response present.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-015 SHALL have port rsp_data  output  N  read result.
REQ-016 SHALL have port rsp_addr  output  ADDR_W  index the result belongs to.
REQ-017 SHALL have port served_count  output  16  number of responses accepted by consumer.

Function
REQ-018 SHALL be a two-stage pipeline: S1 (address held, storage read) and S2 (registered response).
REQ-019 SHALL accept a request when req_valid and req_ready are both 1 on a rising edge; address loads into S1.
REQ-020 SHALL advance S1 to S2 when S1 valid and (S2 empty or rsp_ready=1).
REQ-021 SHALL drive req_ready = !S1_valid or S1 advancing this cycle (combinational, full throughput).
REQ-022 SHALL give latency of exactly 2 clock edges from request acceptance to rsp_valid=1 when unstalled.
REQ-023 SHALL drive rf_rd_addr from S1 address every cycle, so a stalled S1 re-reads storage each cycle.
REQ-024 SHALL select wr_data instead of rf_rd_data when wr_en=1 and wr_addr equals S1 address in the cycle S1 advances (write-through bypass).
REQ-025 SHALL return zero for address 0 regardless of storage content or bypass.
REQ-026 SHALL hold rsp_valid, rsp_data, rsp_addr stable while rsp_valid=1 and rsp_ready=0; writes after capture into S2 are not reflected.
REQ-027 SHALL deliver responses strictly in request order; no drop, no duplicate.
REQ-028 SHALL increment served_count on each rsp_valid and rsp_ready edge, saturating at 16'hFFFF.
REQ-029 SHALL ignore req_addr when req_valid=0.

Reset
REQ-030 SHALL, when reset=1 at a rising edge, clear S1_valid, S2_valid, rsp_data, rsp_addr, served_count to 0, overriding any simultaneous handshake.
REQ-031 SHALL hold req_ready=0 during a cycle with reset=1, and discard in-flight requests on reset mid-operation.
REQ-032 SHALL after reset present rsp_valid=0, rsp_data=0, rsp_addr=0, served_count=0, req_ready=1.

Structure
REQ-033 SHALL take the default N, ADDR_W and the zero-register index from a shared package used by the register file.
REQ-034 SHALL contain the S1 and S2 state as instances of one sub-module, pipe_stage (valid bit, payload, load, clear), with no other sub-modules.

Verification
REQ-035 SHALL cover: storage[5]=0x1234_5678, request addr 5, rsp_ready=1 -> rsp_valid at edge 2, rsp_data=0x1234_5678, rsp_addr=5.
REQ-036 SHALL cover: request addr 7 with wr_en=1, wr_addr=7, wr_data=0xDEAD_BEEF in the S1 cycle -> rsp_data=0xDEAD_BEEF.
REQ-037 SHALL cover: back-to-back requests 1,2,3 with rsp_ready=0 for 4 cycles -> req_ready falls after 2 accepts, outputs held at addr 1, then 1,2,3 in order after release.
REQ-038 SHALL cover: storage[0]=0xFFFF_FFFF, request addr 0 -> rsp_data=0.
REQ-039 SHALL cover: reset=1 asserted while S1 and S2 valid -> next cycle rsp_valid=0, served_count=0, req_ready=1, no stale response later.
REQ-040 SHALL cover: served_count preloaded via 65535 accepted responses, one more accept -> remains 0xFFFF.
